mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/mul_arbiter.sv | 107 ++++++++++
 tb/tb_mul_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// Shared types and default constants for the round-robin multiply-by-constant arbiter.
package mul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_CONSTANT   = 7;
  localparam int DEFAULT_NUM_REQ    = 4;

  // Requester index width; a single requester bit is still carried for NUM_REQ <= 2.
  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from last_grant+1, wrapping, and
// returns a one-hot grant plus its binary index (all zero when nothing requests).
module rr_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int ID_W    = id_width(DEFAULT_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  // Walk offsets from farthest to nearest so the nearest active requester wins.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant     = '0;
    grant_idx = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == ((int'(last_grant) + off) % NUM_REQ) && req[i]) begin
          grant     = '0;
          grant[i]  = 1'b1;
          grant_idx = ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one registered multiply-by-CONSTANT stage among NUM_REQ requesters.
// IDLE grants one requester, MUL computes, OUT holds the result until accepted.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int CONSTANT   = DEFAULT_CONSTANT,
  parameter  int NUM_REQ    = DEFAULT_NUM_REQ,
  localparam int ID_W       = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [ID_W-1:0]               out_id,
  input  logic                          out_ready,
  output logic                          busy
);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   operand_q, operand_d;
  logic [DATA_WIDTH-1:0]   product_q, product_d;
  logic [ID_W-1:0]         id_q, id_d;
  logic [ID_W-1:0]         out_id_q, out_id_d;
  logic [ID_W-1:0]         last_grant_q, last_grant_d;

  logic [NUM_REQ-1:0]      grant;
  logic [ID_W-1:0]         grant_idx;
  logic [DATA_WIDTH-1:0]   grant_op;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  always_comb begin
    grant_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_op = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Outputs are gated by rst_n so they drop immediately while reset is held.
  assign req_ready = (rst_n && state_q == IDLE) ? grant : '0;
  assign out_valid = rst_n && (state_q == OUT);
  assign busy      = rst_n && (state_q != IDLE);
  assign out_data  = product_q;
  assign out_id    = out_id_q;

  always_comb begin
    state_d      = state_q;
    operand_d    = operand_q;
    product_d    = product_q;
    id_d         = id_q;
    out_id_d     = out_id_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          operand_d    = grant_op;
          id_d         = grant_idx;
          last_grant_d = grant_idx;
          state_d      = MUL;
        end
      end
      MUL: begin
        // Product and its owner update together so out_id never runs ahead of out_data.
        product_d = DATA_WIDTH'(operand_q * DATA_WIDTH'(CONSTANT));
        out_id_d  = id_q;
        state_d   = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: every datapath register is reset, not just the FSM, so out_data/out_id read 0 after reset.
    if (!rst_n) begin
      state_q      <= IDLE;
      operand_q    <= '0;
      product_q    <= '0;
      id_q         <= '0;
      out_id_q     <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
    end else begin
      // NOTE: non-blocking assignments so all registers sample the same pre-edge values.
      state_q      <= state_d;
      operand_q    <= operand_d;
      product_q    <= product_d;
      id_q         <= id_d;
      out_id_q     <= out_id_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: a vector table of single requests plus
// hand-written fairness, backpressure, reset and late-arrival sequences.
module tb_mul_arbiter;

  localparam int DW  = 8;
  localparam int NR  = 4;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic [IDW-1:0]   out_id;
  logic             out_ready;
  logic             busy;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int        id;
    logic [7:0] op;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  mul_arbiter #(
    .DATA_WIDTH (DW),
    .CONSTANT   (7),
    .NUM_REQ    (NR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int id, input logic [DW-1:0] op);
    logic [NR*DW-1:0] m;
    logic [NR*DW-1:0] v;
    m = {{(NR*DW-DW){1'b0}}, {DW{1'b1}}} << (id*DW);
    v = {{(NR*DW-DW){1'b0}}, op} << (id*DW);
    req_data = (req_data & ~m) | v;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [NR-1:0] onehot(input int id);
    return NR'(1) << id;
  endfunction

  initial begin
    vecs[0] = '{id: 0, op: 8'd5,   exp: 8'd35};
    vecs[1] = '{id: 1, op: 8'd200, exp: 8'd120};
    vecs[2] = '{id: 2, op: 8'd0,   exp: 8'd0};
    vecs[3] = '{id: 3, op: 8'd255, exp: 8'd249};
    vecs[4] = '{id: 2, op: 8'd37,  exp: 8'd3};
    vecs[5] = '{id: 1, op: 8'd36,  exp: 8'd252};

    // Reset: outputs forced low while rst_n is held, registers cleared by the edge.
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_data  = 32'h04030201;
    out_ready = 1'b1;
    #1;
    check("rst req_ready", req_ready, 0);
    check("rst out_valid", out_valid, 0);
    check("rst busy", busy, 0);
    step();
    check("rst out_data", out_data, 0);
    check("rst out_id", out_id, 0);
    check("rst held req_ready", req_ready, 0);
    req_valid = '0;
    rst_n     = 1'b1;
    step();

    // Single-request table: grant in cycle 0, result in cycle 2, IDLE in cycle 3.
    for (int k = 0; k < 6; k++) begin
      req_valid = onehot(vecs[k].id);
      put(vecs[k].id, vecs[k].op);
      #1;
      check("vec c0 req_ready", req_ready, onehot(vecs[k].id));
      check("vec c0 busy", busy, 0);
      step();
      req_valid = '0;
      #1;
      check("vec c1 out_valid", out_valid, 0);
      check("vec c1 busy", busy, 1);
      check("vec c1 req_ready", req_ready, 0);
      step();
      #1;
      check("vec c2 out_valid", out_valid, 1);
      check("vec c2 out_data", out_data, vecs[k].exp);
      check("vec c2 out_id", out_id, vecs[k].id);
      step();
      #1;
      check("vec c3 busy", busy, 0);
      check("vec c3 out_valid", out_valid, 0);
      check("vec c3 out_data held", out_data, vecs[k].exp);
      check("vec c3 out_id held", out_id, vecs[k].id);
    end

    // Fairness: all valid from reset grants 0,1,2,3,0 every 3 cycles.
    do_reset();
    req_data = {8'd4, 8'd3, 8'd2, 8'd1};
    req_valid = 4'hF;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("fair grant", req_ready, onehot(k % NR));
      step();
      step();
      #1;
      check("fair out_id", out_id, k % NR);
      check("fair out_data", out_data, ((k % NR) + 1) * 7);
      step();
    end
    req_valid = '0;

    // Backpressure: last grant was 0, only requester 1 valid.
    put(1, 8'd10);
    req_valid = 4'b0010;
    out_ready = 1'b0;
    #1;
    check("bp grant", req_ready, 4'b0010);
    step();
    req_valid = 4'hF;
    step();
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp out_valid", out_valid, 1);
      check("bp out_data", out_data, 70);
      check("bp out_id", out_id, 1);
      check("bp req_ready", req_ready, 0);
      check("bp busy", busy, 1);
      step();
    end
    out_ready = 1'b1;
    step();
    #1;
    check("bp release busy", busy, 0);
    check("bp next grant", req_ready, 4'b0100);
    step();
    req_valid = '0;
    step();
    step();

    // Reset in MUL: operation discarded, search restarts from requester 0.
    put(0, 8'd9);
    put(2, 8'd11);
    put(3, 8'd12);
    req_valid = 4'b0001;
    #1;
    check("rmid grant", req_ready, 4'b0001);
    step();
    rst_n     = 1'b0;
    req_valid = 4'b1100;
    #1;
    check("rmid held ready", req_ready, 0);
    check("rmid held busy", busy, 0);
    step();
    rst_n = 1'b1;
    #1;
    check("rmid out_valid", out_valid, 0);
    check("rmid busy", busy, 0);
    check("rmid out_data", out_data, 0);
    check("rmid first grant", req_ready, 4'b0100);
    step();
    req_valid = '0;
    step();
    #1;
    check("rmid result data", out_data, 77);
    check("rmid result id", out_id, 2);
    step();

    // Late arrival: requester 2 raises valid while requester 1 is in MUL.
    put(1, 8'd3);
    req_valid = 4'b0010;
    #1;
    check("late grant1", req_ready, 4'b0010);
    step();
    req_valid = 4'b0100;
    #1;
    check("late mul ready", req_ready, 0);
    step();
    #1;
    check("late out ready", req_ready, 0);
    check("late out_id", out_id, 1);
    check("late out_data", out_data, 21);
    step();
    #1;
    check("late grant2", req_ready, 4'b0100);
    step();
    req_valid = '0;
    step();
    #1;
    check("late2 out_data", out_data, 77);
    check("late2 out_id", out_id, 2);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
